serial_add_ctrl: RTL and testbench

Bit-serial adder controller that sequences the 1-bit `adder1` cell to add two WIDTH-bit operands LSB-first over WIDTH cycles.
- Accepts operands through a valid/ready input handshake.
- Keeps the running carry in a register.
- Presents the WIDTH-bit sum and carry-out through a valid/ready output handshake.
- Sits between a requesting datapath and the shared 1-bit adder resource.

---
 rtl/serial_add_pkg.sv | 25 ++
 rtl/adder1.sv | 18 +
 rtl/full_adder_bit.sv | 36 +++
 rtl/serial_add_ctrl.sv | 112 +++++++++++
 tb/tb_serial_add_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared state encoding and width helper for the bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = c_ST_IDLE,
        RUN  = c_ST_RUN,
        DONE = c_ST_DONE
    } state_e;

    // Counter must hold values 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder1.sv
`default_nettype none
// ============================================================================
// Module      : adder1
// Description : 1-bit half-adder cell shared by the serial datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module adder1 (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule
`default_nettype wire

// File: rtl/full_adder_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_bit
// Description : Full adder built from two adder1 cells plus a carry OR.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_s0;
    logic w_carry1;
    logic w_carry2;

    adder1 u_ha0 (
        .a (a),
        .b (b),
        .s (w_s0),
        .c (w_carry1)
    );

    adder1 u_ha1 (
        .a (w_s0),
        .b (ci),
        .s (s),
        .c (w_carry2)
    );

    assign co = w_carry1 | w_carry2;

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Sequences a 1-bit full adder over WIDTH cycles, LSB first,
//               with valid/ready handshakes on operand and result sides.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int             CNT_W  = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_valid;

    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_sum_next;

    full_adder_bit u_fa (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // New bit enters at the MSB so after WIDTH shifts bit 0 lands at the LSB.
    if (WIDTH == 1) begin : g_sum_w1
        assign w_sum_next = w_s;
    end else begin : g_sum_wn
        assign w_sum_next = {w_s, r_sum[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_cin;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_next;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_cout  <= w_co;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign out_valid = r_valid;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Directed vector bench for serial_add_ctrl (WIDTH=8 and WIDTH=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_cout;
    logic       busy;

    logic       v1_in_valid;
    logic       v1_in_ready;
    logic [0:0] v1_in_a;
    logic [0:0] v1_in_b;
    logic       v1_in_cin;
    logic       v1_out_valid;
    logic       v1_out_ready;
    logic [0:0] v1_out_sum;
    logic       v1_out_cout;
    logic       v1_busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs [8];

    serial_add_ctrl #(.WIDTH(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1_in_valid),
        .in_ready  (v1_in_ready),
        .in_a      (v1_in_a),
        .in_b      (v1_in_b),
        .in_cin    (v1_in_cin),
        .out_valid (v1_out_valid),
        .out_ready (v1_out_ready),
        .out_sum   (v1_out_sum),
        .out_cout  (v1_out_cout),
        .busy      (v1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called #1 after an edge; returns edges elapsed until out_valid (bounded).
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic handshake(input string nm);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, " valid_drop"}, out_valid, 0);
        chk({nm, " ready_back"}, in_ready, 1);
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int cyc;
        @(negedge clk);
        chk({nm, " in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_cin   = v.cin;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        in_cin   = 1'($urandom);
        wait_valid(cyc);
        chk({nm, " latency"}, cyc, 8);
        chk({nm, " sum"}, out_sum, v.sum);
        chk({nm, " cout"}, out_cout, v.cout);
        handshake(nm);
    endtask

    initial begin
        int         cyc;
        logic [7:0] held_sum;
        logic       held_cout;

        vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
        vecs[2] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, sum: 8'h00, cout: 1'b1};
        vecs[3] = '{a: 8'h3C, b: 8'h42, cin: 1'b0, sum: 8'h7E, cout: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};
        vecs[5] = '{a: 8'h7F, b: 8'h00, cin: 1'b1, sum: 8'h80, cout: 1'b0};
        vecs[6] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
        vecs[7] = '{a: 8'h12, b: 8'h34, cin: 1'b0, sum: 8'h46, cout: 1'b0};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        in_cin       = 1'b0;
        out_ready    = 1'b0;
        v1_in_valid  = 1'b0;
        v1_in_a      = '0;
        v1_in_b      = '0;
        v1_in_cin    = 1'b0;
        v1_out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", in_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_sum", out_sum, 0);
        chk("rst out_cout", out_cout, 0);
        chk("rst w1 in_ready", v1_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold through 5 stalled DONE cycles.
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'h3C; in_b = 8'h42; in_cin = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(cyc);
        chk("bp latency", cyc, 8);
        held_sum  = out_sum;
        held_cout = out_cout;
        chk("bp sum", held_sum, 8'h7E);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp valid", out_valid, 1);
            chk("bp sum_hold", out_sum, 8'h7E);
            chk("bp cout_hold", out_cout, 0);
            chk("bp in_ready", in_ready, 0);
        end
        handshake("bp");

        // in_valid held with changing operands during RUN/DONE.
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22; in_cin = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("hold in_ready", in_ready, 0);
            in_a = 8'($urandom);
            @(posedge clk);
            #1;
        end
        chk("hold valid", out_valid, 1);
        chk("hold sum", out_sum, 8'h33);
        chk("hold cout", out_cout, 0);
        in_a = 8'h05;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hold idle_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("hold reaccept", busy, 1);
        in_valid = 1'b0;
        in_a     = 8'hEE;
        wait_valid(cyc);
        chk("hold2 latency", cyc, 8);
        chk("hold2 sum", out_sum, 8'h27);
        handshake("hold2");

        // Reset three cycles into RUN.
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_cin = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid out_valid", out_valid, 0);
        chk("mid out_sum", out_sum, 0);
        chk("mid busy", busy, 0);
        chk("mid in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op('{a: 8'h10, b: 8'h20, cin: 1'b0, sum: 8'h30, cout: 1'b0}, "post_rst");

        // WIDTH=1 instance: a single RUN cycle.
        @(negedge clk);
        v1_in_valid = 1'b1; v1_in_a = 1'b1; v1_in_b = 1'b1; v1_in_cin = 1'b1;
        @(posedge clk);
        #1;
        v1_in_valid = 1'b0;
        chk("w1 busy", v1_busy, 1);
        chk("w1 early_valid", v1_out_valid, 0);
        @(posedge clk);
        #1;
        chk("w1 valid", v1_out_valid, 1);
        chk("w1 sum", v1_out_sum, 1);
        chk("w1 cout", v1_out_cout, 1);
        v1_out_ready = 1'b1;
        @(posedge clk);
        #1;
        v1_out_ready = 1'b0;
        chk("w1 in_ready", v1_in_ready, 1);
        @(negedge clk);
        v1_in_valid = 1'b1; v1_in_a = 1'b0; v1_in_b = 1'b1; v1_in_cin = 1'b0;
        @(posedge clk);
        #1;
        v1_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("w1b valid", v1_out_valid, 1);
        chk("w1b sum", v1_out_sum, 1);
        chk("w1b cout", v1_out_cout, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
